cache_mem_arbiter: RTL and testbench

//  Shares the single multi-cycle main memory between the I-cache and D-cache miss handlers.

---
 rtl/cache_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one multi-cycle main memory between the I-cache and D-cache miss handlers: 8-word block fills
// and single-word write-through stores. Define ARB_ROUND_ROBIN_EN to alternate grants between pending misses.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned WORDS_PER_BLK = 8,
  parameter int unsigned MEM_LAT       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [DATA_W-1:0] fill_data,
  output logic [2:0]        fill_idx,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_done,
  output logic              busy
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned BLK_BYTES = 2 * WORDS_PER_BLK;
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(BLK_BYTES - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

  state_t            state;
  logic [CNT_W-1:0]  issueCnt;
  logic [CNT_W-1:0]  retCnt;
  logic [ADDR_W-1:0] base;
  logic              filling;
  logic              lastRet;
  logic              grantD;

  assign filling = (state == FILL_I) || (state == FILL_D);
  assign lastRet = filling && mem_rvalid && (retCnt == CNT_W'(WORDS_PER_BLK - 1));

`ifdef ARB_ROUND_ROBIN_EN
  logic lastD;
  // With both misses pending, the side not served last wins.
  assign grantD = d_miss && !(i_miss && lastD);
`else
  assign grantD = d_miss;
`endif

  // Fill strobes follow mem_rvalid in the same cycle so the caches write the word as it arrives.
  assign i_fill_we   = mem_rvalid && (state == FILL_I);
  assign d_fill_we   = mem_rvalid && (state == FILL_D);
  assign i_fill_done = lastRet && (state == FILL_I);
  assign d_fill_done = lastRet && (state == FILL_D);
  assign fill_data   = (i_fill_we || d_fill_we) ? mem_rdata : '0;
  assign fill_idx    = retCnt[2:0];
  assign busy        = (state != IDLE);

  // Arbitration state, counters and registered memory strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      issueCnt  <= '0;
      retCnt    <= '0;
      base      <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      d_wr_done <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      lastD     <= 1'b0;
`endif
    end else begin
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      d_wr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          issueCnt <= '0;
          retCnt   <= '0;
          if (d_wr_req) begin
            state     <= WRITE;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= d_wr_addr;
            mem_wdata <= d_wr_data;
            d_wr_done <= 1'b1;
          end else if (grantD) begin
            state <= FILL_D;
            base  <= d_miss_addr & BASE_MASK;
`ifdef ARB_ROUND_ROBIN_EN
            lastD <= 1'b1;
`endif
          end else if (i_miss) begin
            state <= FILL_I;
            base  <= i_miss_addr & BASE_MASK;
`ifdef ARB_ROUND_ROBIN_EN
            lastD <= 1'b0;
`endif
          end
        end
        WRITE: state <= IDLE;
        FILL_I, FILL_D: begin
          if (issueCnt < CNT_W'(WORDS_PER_BLK)) begin
            mem_en   <= 1'b1;
            mem_addr <= base + (ADDR_W'(issueCnt) << 1);
            issueCnt <= issueCnt + CNT_W'(1);
          end
          if (mem_rvalid) retCnt <= retCnt + CNT_W'(1);
          if (lastRet) state <= IDLE;
          // A memory honouring MEM_LAT never has more reads outstanding than this.
          assert (int'(issueCnt) - int'(retCnt) <= int'(MEM_LAT) + 1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed requests push expected memory accesses and fill
// writes; a negedge monitor pops and compares them against a fixed-latency memory model.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned MEM_LAT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_miss = 1'b0;
  logic [ADDR_W-1:0] i_miss_addr = '0;
  logic              d_miss = 1'b0;
  logic [ADDR_W-1:0] d_miss_addr = '0;
  logic              d_wr_req = 1'b0;
  logic [ADDR_W-1:0] d_wr_addr = '0;
  logic [DATA_W-1:0] d_wr_data = '0;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, fill_data;
  logic              mem_rvalid;
  logic [2:0]        fill_idx;
  logic              i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_BLK(8), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_done(d_wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Memory model: a read seen in cycle n returns in cycle n+MEM_LAT; not reset, so late returns persist.
  logic [MEM_LAT-1:0] pipeV = '0;
  logic [ADDR_W-1:0]  pipeA [MEM_LAT];
  always @(posedge clk) begin
    pipeV    <= {pipeV[MEM_LAT-2:0], mem_en && !mem_wr};
    pipeA[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) pipeA[i] <= pipeA[i-1];
  end
  assign mem_rvalid = pipeV[MEM_LAT-1];
  assign mem_rdata  = memWord(pipeA[MEM_LAT-1]);

  typedef struct { logic wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; int cyc; } memExp_t;
  typedef struct { logic isD; logic [2:0] idx; logic [DATA_W-1:0] data; logic done; int cyc; } fillExp_t;
  memExp_t  memQ[$];
  fillExp_t fillQ[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s (cyc %0d)", name, what, cyc);
  endtask

  // Expect a fill of block `base` accepted at edge t (t<0: timing not checked).
  task automatic expectFill(input logic isD, input logic [ADDR_W-1:0] base, input int t,
                            input int nIssue, input int nRet);
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < nIssue; k++) begin
      a = base + ADDR_W'(2 * k);
      memQ.push_back('{1'b0, a, 16'h0, (t < 0) ? -1 : t + 1 + k});
    end
    for (int k = 0; k < nRet; k++) begin
      a = base + ADDR_W'(2 * k);
      fillQ.push_back('{isD, 3'(k), memWord(a), (k == 7), (t < 0) ? -1 : t + 1 + int'(MEM_LAT) + k});
    end
  endtask

  // Monitor: every memory access and every fill write must match the next expected item.
  always @(negedge clk) begin
    memExp_t  me;
    fillExp_t fe;
    if (mem_en === 1'b1) begin
      if (memQ.size() == 0) flag("mem_unexpected", $sformatf("addr %h wr %b", mem_addr, mem_wr));
      else begin
        me = memQ.pop_front();
        chk("mem_access", 64'({mem_wr, mem_addr, (mem_wr ? mem_wdata : 16'h0), d_wr_done}),
                          64'({me.wr, me.addr, (me.wr ? me.wdata : 16'h0), me.wr}));
        if (me.cyc >= 0) chk("mem_cycle", 64'(cyc), 64'(me.cyc));
      end
    end else if (d_wr_done === 1'b1) flag("wr_done_unexpected", "d_wr_done without mem_en");
    if (i_fill_we === 1'b1 || d_fill_we === 1'b1) begin
      if (fillQ.size() == 0) flag("fill_unexpected", $sformatf("i_we %b d_we %b idx %0d", i_fill_we, d_fill_we, fill_idx));
      else begin
        fe = fillQ.pop_front();
        chk("fill_write", 64'({i_fill_we, d_fill_we, fill_idx, fill_data, i_fill_done, d_fill_done}),
                          64'({!fe.isD, fe.isD, fe.idx, fe.data, fe.done && !fe.isD, fe.done && fe.isD}));
        if (fe.cyc >= 0) chk("fill_cycle", 64'(cyc), 64'(fe.cyc));
      end
    end else if (i_fill_done === 1'b1 || d_fill_done === 1'b1) flag("done_unexpected", "done pulse without fill write");
  end

  // 0: i_fill_done, 1: d_fill_done, 2: d_wr_done; returns at the negedge where it is seen.
  task automatic waitDone(input int which, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = i_fill_done;
        1:       seen = d_fill_done;
        default: seen = d_wr_done;
      endcase
    end
    if (!seen) flag(name, "timed out waiting for done");
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && (memQ.size() != 0 || fillQ.size() != 0); i++) @(negedge clk);
    checks++;
    if (memQ.size() != 0 || fillQ.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d mem and %0d fill items outstanding, required 0", name, memQ.size(), fillQ.size());
      memQ.delete();
      fillQ.delete();
    end
    repeat (MEM_LAT + 2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    int dLeft;
    int iLeft;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx, i_fill_we, d_fill_we,
                              i_fill_done, d_fill_done, d_wr_done, busy}), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'h0);

    // 1: I fill at 0x0046 -> block 0x0040, full latency profile
    c = cyc;
    expectFill(1'b0, 16'h0040, c + 1, 8, 8);
    i_miss_addr = 16'h0046;
    i_miss = 1'b1;
    @(negedge clk);
    chk("t1_busy_start", 64'(busy), 64'h1);
    waitDone(0, "t1_done");
    chk("t1_done_cycle", 64'(cyc), 64'(c + 13));
    i_miss = 1'b0;
    @(negedge clk);
    chk("t1_busy_end", 64'(busy), 64'h0);
    drain("t1");

    // 2: single store
    c = cyc;
    memQ.push_back('{1'b1, 16'h1234, 16'hBEEF, c + 1});
    d_wr_addr = 16'h1234;
    d_wr_data = 16'hBEEF;
    d_wr_req  = 1'b1;
    waitDone(2, "t2_done");
    chk("t2_busy_write", 64'(busy), 64'h1);
    d_wr_req = 1'b0;
    @(negedge clk);
    chk("t2_busy_end", 64'(busy), 64'h0);
    drain("t2");

    // 2b: store beats a simultaneous D miss
    c = cyc;
    memQ.push_back('{1'b1, 16'h0300, 16'h5A5A, c + 1});
    expectFill(1'b1, 16'h0200, c + 3, 8, 8);
    d_wr_addr = 16'h0300;
    d_wr_data = 16'h5A5A;
    d_wr_req = 1'b1;
    d_miss_addr = 16'h020C;
    d_miss = 1'b1;
    waitDone(2, "t2b_wr");
    d_wr_req = 1'b0;
    waitDone(1, "t2b_fill");
    d_miss = 1'b0;
    drain("t2b");

    // 3: I and D together -> D first, I granted right after
    c = cyc;
    expectFill(1'b1, 16'h8000, c + 1, 8, 8);
    expectFill(1'b0, 16'h0100, c + 15, 8, 8);
    d_miss_addr = 16'h8000;
    i_miss_addr = 16'h0100;
    d_miss = 1'b1;
    i_miss = 1'b1;
    waitDone(1, "t3_d");
    d_miss = 1'b0;
    waitDone(0, "t3_i");
    i_miss = 1'b0;
    drain("t3");

    // 4: reset during D fill after 3 returns
    c = cyc;
    expectFill(1'b1, 16'h4000, c + 1, 7, 3);
    d_miss_addr = 16'h4008;
    d_miss = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (d_fill_we) n++;
    end
    if (n < 3) flag("t4_returns", "timed out waiting for 3 returns");
    rst_n  = 1'b0;
    d_miss = 1'b0;
    @(negedge clk);
    chk("t4_abort", 64'({busy, mem_en, d_fill_done}), 64'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_late", 64'({d_fill_we, d_fill_done, busy, mem_en}), 64'h0);
    end
    drain("t4");

    // 5: block at top of address space
    c = cyc;
    expectFill(1'b1, 16'hFFF0, c + 1, 8, 8);
    d_miss_addr = 16'hFFF2;
    d_miss = 1'b1;
    waitDone(1, "t5_done");
    d_miss = 1'b0;
    drain("t5");

    // 6: both misses held for two blocks each, from a fresh reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    expectFill(1'b1, 16'h2000, -1, 8, 8);
    expectFill(1'b0, 16'h3000, -1, 8, 8);
    expectFill(1'b1, 16'h2100, -1, 8, 8);
    expectFill(1'b0, 16'h3100, -1, 8, 8);
`else
    expectFill(1'b1, 16'h2000, -1, 8, 8);
    expectFill(1'b1, 16'h2100, -1, 8, 8);
    expectFill(1'b0, 16'h3000, -1, 8, 8);
    expectFill(1'b0, 16'h3100, -1, 8, 8);
`endif
    dLeft = 2;
    iLeft = 2;
    d_miss_addr = 16'h2000;
    i_miss_addr = 16'h3000;
    d_miss = 1'b1;
    i_miss = 1'b1;
    for (int i = 0; i < 150 && (dLeft > 0 || iLeft > 0); i++) begin
      @(negedge clk);
      if (d_fill_done) begin
        dLeft--;
        if (dLeft == 0) d_miss = 1'b0;
        else d_miss_addr = 16'h2100;
      end
      if (i_fill_done) begin
        iLeft--;
        if (iLeft == 0) i_miss = 1'b0;
        else i_miss_addr = 16'h3100;
      end
    end
    if (dLeft > 0 || iLeft > 0) flag("t6_order", $sformatf("%0d D and %0d I fills never completed", dLeft, iLeft));
    d_miss = 1'b0;
    i_miss = 1'b0;
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
